// File: rtl/latency_buffer_pkg.sv
// Shared constants and counter type for latency_buffer and the arbiters that sample its count_out.
package latency_buffer_pkg;

  localparam int unsigned DEPTH_DFLT = 8;
  localparam int unsigned PTR_W      = $clog2(DEPTH_DFLT);
  localparam int unsigned CNT_W      = PTR_W + 1;

  // Occupancy/credit counter for the default depth; holds 0..DEPTH inclusive.
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/latency_buffer_mem.sv
// DEPTH x DATA_WIDTH result storage: one synchronous write port, one asynchronous read port.
module latency_buffer_mem
  import latency_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DEPTH_DFLT,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/latency_buffer.sv
// Credit-based return buffer for a non-stalling fixed-latency pipeline.
// Optional sticky protocol-error flag built when LATENCY_BUFFER_ERR_CHECK_EN is defined.
module latency_buffer
  import latency_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DEPTH_DFLT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    issue_valid_in,
  output logic                    issue_ready_out,
  input  logic                    ret_valid_in,
  input  logic [DATA_WIDTH-1:0]   ret_data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic                    err_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW:0]   CRED_MAX = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW:0]   credit_used;

  logic issue_fire;
  logic ret_bad;
  logic ret_ok;
  logic pop;

  // Credits are judged from registers only, so issue_ready_out has no input path.
  assign credit_used     = {1'b0, inflight_q} + {1'b0, occ_q};
  assign issue_ready_out = credit_used < CRED_MAX;

  assign issue_fire = issue_valid_in && issue_ready_out;
  assign ret_bad    = ret_valid_in && ((inflight_q == '0) || (occ_q == CNT_FULL));
  assign ret_ok     = ret_valid_in && !ret_bad;
  assign valid_out  = (occ_q != '0);
  assign pop        = valid_out && ready_in;
  assign count_out  = occ_q;

  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !ret_ok) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!issue_fire && ret_ok) begin
      inflight_d = inflight_q - CNT_ONE;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (ret_ok && !pop) begin
      occ_d = occ_q + CNT_ONE;
    end else if (!ret_ok && pop) begin
      occ_d = occ_q - CNT_ONE;
    end
  end

  // DEPTH is a power of two, so the natural PW-bit rollover is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ret_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      inflight_q <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  latency_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk_i   (clk_in),
    .we_i    (ret_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (ret_data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

`ifdef LATENCY_BUFFER_ERR_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q || ret_bad;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule
